// File: rtl/bp_update_pkg.sv
// rtl/bp_update_pkg.sv - shared types and defaults for the branch-predictor update scheduler
package bp_update_pkg;

    localparam int BP_DEFAULT_SIZE    = 32;
    localparam int BP_DEFAULT_ENTRIES = 32;
    localparam int BP_DEFAULT_DEPTH   = 8;
    localparam int BP_DEFAULT_GHIST_W = $clog2(BP_DEFAULT_ENTRIES) + 3;

    // Queue entry layout; the scheduler packs its flat entries in this same field order.
    typedef struct packed {
        logic                          is_jalr;
        logic                          mispred;
        logic [BP_DEFAULT_SIZE-1:0]    pc;
        logic [BP_DEFAULT_SIZE-1:0]    target;
        logic [BP_DEFAULT_GHIST_W-1:0] ghist;
    } bp_update_t;

    localparam int BP_UPDATE_W = $bits(bp_update_t);

endpackage

// File: rtl/bp_update_fifo.sv
// rtl/bp_update_fifo.sv - 3-write/1-read circular buffer holding pending predictor updates
module bp_update_fifo #(
    parameter int W     = bp_update_pkg::BP_UPDATE_W,
    parameter int DEPTH = bp_update_pkg::BP_DEFAULT_DEPTH,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          wr_num_i,
    input  logic [2:0][W-1:0]   wr_data_i,
    input  logic                rd_en_i,
    output logic [W-1:0]        rd_data_o,
    output logic [CW-1:0]       count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wr_idx [3];

    // Consecutive write positions; AW-bit arithmetic wraps modulo DEPTH.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            wr_idx[i] = wr_ptr_q + AW'(i);
        end
    end

    // Next-state for pointers, occupancy and storage; writes land only in the first wr_num_i positions.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(wr_num_i);
        rd_ptr_d = rd_ptr_q + AW'(rd_en_i);
        count_d  = count_q + CW'(wr_num_i) - CW'(rd_en_i);
        mem_d    = mem_q;
        for (int i = 0; i < 3; i++) begin
            if (2'(i) < wr_num_i) begin
                mem_d[wr_idx[i]] = wr_data_i[i];
            end
        end
    end

    // Control state clears asynchronously so queued entries vanish the moment reset rises.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data_o = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o   = count_q;

endmodule

// File: rtl/bp_update_scheduler.sv
// rtl/bp_update_scheduler.sv - filters, compacts and queues BRAT updates for the predictor write port
module bp_update_scheduler
    import bp_update_pkg::*;
#(
    parameter int size    = BP_DEFAULT_SIZE,
    parameter int ENTRIES = BP_DEFAULT_ENTRIES,
    parameter int DEPTH   = BP_DEFAULT_DEPTH,
    localparam int INDEX_WIDTH = $clog2(ENTRIES),
    localparam int GW = INDEX_WIDTH + 3,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       upd_valid_i,
    input  logic [2:0]       upd_mispred_i,
    input  logic [2:0]       upd_is_jalr_i,
    input  logic [size-1:0]  upd_pc_i_0,
    input  logic [size-1:0]  upd_pc_i_1,
    input  logic [size-1:0]  upd_pc_i_2,
    input  logic [size-1:0]  upd_target_i_0,
    input  logic [size-1:0]  upd_target_i_1,
    input  logic [size-1:0]  upd_target_i_2,
    input  logic [GW-1:0]    upd_ghist_i_0,
    input  logic [GW-1:0]    upd_ghist_i_1,
    input  logic [GW-1:0]    upd_ghist_i_2,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             out_is_jalr_o,
    output logic             out_mispred_o,
    output logic [size-1:0]  out_pc_o,
    output logic [size-1:0]  out_target_o,
    output logic [GW-1:0]    out_ghist_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic [7:0]       drop_cnt_o
);

    localparam int EW = 2 + 2 * size + GW;

    logic [2:0]          elig;
    logic [2:0][EW-1:0]  slot_data;
    logic [2:0][EW-1:0]  cmp_data;
    logic [1:0]          n_elig;
    logic [1:0]          accepted;
    logic [1:0]          dropped;
    logic [CW-1:0]       free_space;
    logic [8:0]          drop_sum;
    logic [7:0]          drop_cnt_q, drop_cnt_d;
    logic                rd_en;
    logic [EW-1:0]       rd_data;

    assign slot_data[0] = {upd_is_jalr_i[0], upd_mispred_i[0], upd_pc_i_0, upd_target_i_0, upd_ghist_i_0};
    assign slot_data[1] = {upd_is_jalr_i[1], upd_mispred_i[1], upd_pc_i_1, upd_target_i_1, upd_ghist_i_1};
    assign slot_data[2] = {upd_is_jalr_i[2], upd_mispred_i[2], upd_pc_i_2, upd_target_i_2, upd_ghist_i_2};

    // A mispredicted older slot squashes every younger slot in the same cycle.
    always_comb begin
        elig[0] = upd_valid_i[0];
        elig[1] = upd_valid_i[1] & ~(upd_valid_i[0] & upd_mispred_i[0]);
        elig[2] = upd_valid_i[2] & ~(upd_valid_i[0] & upd_mispred_i[0])
                                 & ~(upd_valid_i[1] & upd_mispred_i[1]);
    end

    // Pack eligible slots oldest-first into adjacent write lanes so no queue gaps appear.
    always_comb begin
        n_elig   = '0;
        cmp_data = '0;
        for (int k = 0; k < 3; k++) begin
            if (elig[k]) begin
                cmp_data[n_elig] = slot_data[k];
                n_elig           = n_elig + 2'd1;
            end
        end
    end

    // Space is measured before this cycle's dequeue; overflow drops the youngest and counts them.
    always_comb begin
        free_space = CW'(DEPTH) - count_o;
        accepted   = (CW'(n_elig) > free_space) ? free_space[1:0] : n_elig;
        dropped    = n_elig - accepted;
        drop_sum   = {1'b0, drop_cnt_q} + 9'(dropped);
        drop_cnt_d = drop_sum[8] ? 8'hff : drop_sum[7:0];
    end

    // Saturating drop counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign out_valid_o = (count_o != '0);
    assign rd_en       = out_valid_o & out_ready_i;

    bp_update_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_num_i  (accepted),
        .wr_data_i (cmp_data),
        .rd_en_i   (rd_en),
        .rd_data_o (rd_data),
        .count_o   (count_o)
    );

    assign {out_is_jalr_o, out_mispred_o, out_pc_o, out_target_o, out_ghist_o} = rd_data;
    assign full_o     = (count_o == CW'(DEPTH));
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_bp_update_scheduler.sv
// tb/tb_bp_update_scheduler.sv - scoreboard bench for bp_update_scheduler
module tb_bp_update_scheduler;

    localparam int SZ    = 32;
    localparam int DEPTH = 8;
    localparam int GW    = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    upd_valid_i, upd_mispred_i, upd_is_jalr_i;
    logic [SZ-1:0] upd_pc_i_0, upd_pc_i_1, upd_pc_i_2;
    logic [SZ-1:0] upd_target_i_0, upd_target_i_1, upd_target_i_2;
    logic [GW-1:0] upd_ghist_i_0, upd_ghist_i_1, upd_ghist_i_2;
    logic          out_valid_o, out_ready_i, out_is_jalr_o, out_mispred_o;
    logic [SZ-1:0] out_pc_o, out_target_o;
    logic [GW-1:0] out_ghist_o;
    logic [3:0]    count_o;
    logic          full_o;
    logic [7:0]    drop_cnt_o;

    always #5 clk = ~clk;

    bp_update_scheduler #(.size(SZ), .ENTRIES(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .upd_valid_i(upd_valid_i), .upd_mispred_i(upd_mispred_i), .upd_is_jalr_i(upd_is_jalr_i),
        .upd_pc_i_0(upd_pc_i_0), .upd_pc_i_1(upd_pc_i_1), .upd_pc_i_2(upd_pc_i_2),
        .upd_target_i_0(upd_target_i_0), .upd_target_i_1(upd_target_i_1), .upd_target_i_2(upd_target_i_2),
        .upd_ghist_i_0(upd_ghist_i_0), .upd_ghist_i_1(upd_ghist_i_1), .upd_ghist_i_2(upd_ghist_i_2),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_is_jalr_o(out_is_jalr_o), .out_mispred_o(out_mispred_o),
        .out_pc_o(out_pc_o), .out_target_o(out_target_o), .out_ghist_o(out_ghist_o),
        .count_o(count_o), .full_o(full_o), .drop_cnt_o(drop_cnt_o)
    );

    typedef struct {
        logic          jalr;
        logic          mis;
        logic [SZ-1:0] pc;
        logic [SZ-1:0] tgt;
        logic [GW-1:0] gh;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   model_drop = 0;
    logic [SZ-1:0] held_pc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [SZ-1:0] tgt_of(input logic [SZ-1:0] pc);
        return pc + 32'h40;
    endfunction

    function automatic logic [GW-1:0] gh_of(input logic [SZ-1:0] pc);
        return pc[7:0] ^ 8'h5a;
    endfunction

    // One clock of stimulus: check head before the edge, update the model, check status after it.
    task automatic cycle(input logic [2:0] v, input logic [2:0] m,
                         input logic [SZ-1:0] p0, input logic [SZ-1:0] p1, input logic [SZ-1:0] p2,
                         input logic rdy);
        logic [SZ-1:0] pcs [3];
        exp_t acc[$];
        logic blocked;
        int   free_n, dropped;
        logic deq;
        pcs[0] = p0; pcs[1] = p1; pcs[2] = p2;
        upd_valid_i    = v;
        upd_mispred_i  = m;
        upd_is_jalr_i  = {p2[2], p1[2], p0[2]};
        upd_pc_i_0 = p0; upd_pc_i_1 = p1; upd_pc_i_2 = p2;
        upd_target_i_0 = tgt_of(p0); upd_target_i_1 = tgt_of(p1); upd_target_i_2 = tgt_of(p2);
        upd_ghist_i_0  = gh_of(p0);  upd_ghist_i_1  = gh_of(p1);  upd_ghist_i_2  = gh_of(p2);
        out_ready_i    = rdy;
        #1;
        chk("out_valid", 64'(out_valid_o), 64'(sb.size() != 0));
        if (sb.size() != 0) begin
            chk("head_pc", 64'(out_pc_o), 64'(sb[0].pc));
            chk("head_target", 64'(out_target_o), 64'(sb[0].tgt));
            chk("head_ghist", 64'(out_ghist_o), 64'(sb[0].gh));
            chk("head_flags", 64'({out_is_jalr_o, out_mispred_o}), 64'({sb[0].jalr, sb[0].mis}));
        end else begin
            chk("idle_zero", 64'({out_is_jalr_o, out_mispred_o, out_pc_o, out_target_o, out_ghist_o} != 0), 64'(0));
        end
        blocked = 1'b0;
        free_n  = DEPTH - sb.size();
        dropped = 0;
        for (int k = 0; k < 3; k++) begin
            if (v[k] && !blocked) begin
                if (acc.size() < free_n) acc.push_back('{pcs[k][2], m[k], pcs[k], tgt_of(pcs[k]), gh_of(pcs[k])});
                else dropped++;
            end
            if (v[k] && m[k]) blocked = 1'b1;
        end
        deq = rdy && (sb.size() != 0);
        @(posedge clk);
        #1;
        if (deq) void'(sb.pop_front());
        foreach (acc[i]) sb.push_back(acc[i]);
        model_drop = (model_drop + dropped > 255) ? 255 : model_drop + dropped;
        chk("count", 64'(count_o), 64'(sb.size()));
        chk("drop_cnt", 64'(drop_cnt_o), 64'(model_drop));
        chk("full", 64'(full_o), 64'(sb.size() == DEPTH));
    endtask

    task automatic idle(input logic rdy);
        cycle(3'b000, 3'b000, 32'h0, 32'h0, 32'h0, rdy);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_count", 64'(count_o), 64'(0));
        chk("rst_valid", 64'(out_valid_o), 64'(0));
        chk("rst_full", 64'(full_o), 64'(0));
        chk("rst_drop", 64'(drop_cnt_o), 64'(0));
        sb.delete();
        model_drop = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        upd_valid_i = '0; upd_mispred_i = '0; upd_is_jalr_i = '0;
        upd_pc_i_0 = '0; upd_pc_i_1 = '0; upd_pc_i_2 = '0;
        upd_target_i_0 = '0; upd_target_i_1 = '0; upd_target_i_2 = '0;
        upd_ghist_i_0 = '0; upd_ghist_i_1 = '0; upd_ghist_i_2 = '0;
        out_ready_i = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Three clean updates, drained in order
        cycle(3'b111, 3'b000, 32'h100, 32'h104, 32'h108, 1'b0);
        chk("three_count", 64'(count_o), 64'(3));
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("drained", 64'(count_o), 64'(0));

        // Slot 0 mispredicted squashes slots 1 and 2
        cycle(3'b111, 3'b001, 32'h120, 32'h124, 32'h128, 1'b0);
        chk("squash_count", 64'(count_o), 64'(1));
        idle(1'b1);

        // Gap in valid bits, and a slot-1 mispredict that squashes only slot 2
        cycle(3'b101, 3'b000, 32'h130, 32'h134, 32'h138, 1'b0);
        cycle(3'b111, 3'b010, 32'h140, 32'h144, 32'h148, 1'b1);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Overflow with simultaneous dequeue: no bypass of freed space
        cycle(3'b111, 3'b000, 32'h150, 32'h154, 32'h158, 1'b0);
        cycle(3'b111, 3'b000, 32'h160, 32'h164, 32'h168, 1'b0);
        cycle(3'b111, 3'b000, 32'h170, 32'h174, 32'h178, 1'b1);
        chk("ovf_count", 64'(count_o), 64'(7));
        chk("ovf_drop", 64'(drop_cnt_o), 64'(1));

        // Full queue stalled for three cycles
        do_reset();
        cycle(3'b111, 3'b000, 32'h200, 32'h204, 32'h208, 1'b0);
        cycle(3'b111, 3'b000, 32'h210, 32'h214, 32'h218, 1'b0);
        cycle(3'b011, 3'b000, 32'h220, 32'h224, 32'h228, 1'b0);
        held_pc = out_pc_o;
        for (int i = 0; i < 3; i++) cycle(3'b111, 3'b000, 32'h300, 32'h304, 32'h308, 1'b0);
        chk("stall_drop", 64'(drop_cnt_o), 64'(9));
        chk("stall_full", 64'(full_o), 64'(1));
        chk("stall_pc", 64'(out_pc_o), 64'(held_pc));
        chk("stall_pc_val", 64'(out_pc_o), 64'(32'h200));

        // Drop counter saturation (300 drops total)
        for (int i = 0; i < 97; i++) cycle(3'b111, 3'b000, 32'h400, 32'h404, 32'h408, 1'b0);
        chk("drop_sat", 64'(drop_cnt_o), 64'(255));

        // Mid-operation reset with 5 queued
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("pre_rst_count", 64'(count_o), 64'(5));
        do_reset();
        cycle(3'b001, 3'b000, 32'h500, 32'h504, 32'h508, 1'b0);
        chk("post_rst_head", 64'(out_pc_o), 64'(32'h500));
        idle(1'b1);
        idle(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
